// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, FSM states and datapath width.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle of the M-extension unit: request from ID/EX,
// stall/result back to the hazard unit and EX-result mux.
interface ex_muldiv_if;
  import muldiv_pkg::*;

  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV32M multiply/divide in EX. One 64-bit shift register
// holds either the product or {remainder, quotient}; 32 steps per op.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  ex_muldiv_if.slave md
);
  import muldiv_pkg::*;

  md_state_e         state_reg, state_next;
  logic [4:0]        cnt_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opa_reg, opb_reg;
  logic [2:0]        op_reg;
  logic              neg_a_reg, neg_b_reg, divz_reg;
  logic [XLEN-1:0]   res_pend_reg, res_last_reg;

  logic              start_ok, done_w;
  logic              signed_a, signed_b, neg_a, neg_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              q_bit;
  logic [2*XLEN-1:0] step_acc, prod;
  logic [XLEN-1:0]   quot, rem, res_calc;

  assign start_ok = (state_reg == IDLE) && md.start_i && !md.flush_i;
  assign done_w   = (state_reg == DONE) && !md.flush_i;

  always_comb begin
    signed_a = (md.op_i == MD_MULH) || (md.op_i == MD_MULHSU) ||
               (md.op_i == MD_DIV)  || (md.op_i == MD_REM);
    signed_b = (md.op_i == MD_MULH) || (md.op_i == MD_DIV) || (md.op_i == MD_REM);
    neg_a    = signed_a && md.rs1_i[XLEN-1];
    neg_b    = signed_b && md.rs2_i[XLEN-1];
  end

  // Multiply adds into the top half and shifts right; divide shifts the
  // dividend MSB into the remainder and a trial subtract decides the quotient bit.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (opb_reg[0] ? {1'b0, opa_reg} : '0);
    div_shift = {acc_reg[2*XLEN-1:XLEN], opa_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_reg};
    q_bit     = ~div_diff[XLEN];
    if (op_reg[2])
      step_acc = {(q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_reg[XLEN-2:0], q_bit};
    else
      step_acc = {mul_sum, acc_reg[XLEN-1:1]};
  end

  // Sign correction on the final step; divide-by-zero remainder falls out
  // naturally as |rs1| with the dividend's sign, i.e. rs1 itself.
  always_comb begin
    prod     = (neg_a_reg ^ neg_b_reg) ? -step_acc : step_acc;
    quot     = step_acc[XLEN-1:0];
    rem      = step_acc[2*XLEN-1:XLEN];
    res_calc = prod[XLEN-1:0];
    case (op_reg)
      MD_MUL:                       res_calc = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_calc = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res_calc = divz_reg ? '1 :
                                               ((neg_a_reg ^ neg_b_reg) ? -quot : quot);
      default:                      res_calc = neg_a_reg ? -rem : rem;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_ok) state_next = BUSY;
      BUSY: begin
        if (md.flush_i)             state_next = IDLE;
        else if (cnt_reg == 5'd31)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      op_reg       <= '0;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      divz_reg     <= 1'b0;
      res_pend_reg <= '0;
      res_last_reg <= '0;
    end else if (start_ok) begin
      op_reg    <= md.op_i;
      neg_a_reg <= neg_a;
      neg_b_reg <= neg_b;
      divz_reg  <= (md.rs2_i == '0);
      opa_reg   <= neg_a ? -md.rs1_i : md.rs1_i;
      opb_reg   <= neg_b ? -md.rs2_i : md.rs2_i;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == BUSY) begin
      if (md.flush_i) begin
        cnt_reg <= '0;
      end else begin
        acc_reg <= step_acc;
        cnt_reg <= cnt_reg + 5'd1;
        if (op_reg[2]) opa_reg <= {opa_reg[XLEN-2:0], 1'b0};
        else           opb_reg <= {1'b0, opb_reg[XLEN-1:1]};
        if (cnt_reg == 5'd31) res_pend_reg <= res_calc;
      end
    end else if (done_w) begin
      res_last_reg <= res_pend_reg;
    end
  end

  assign md.busy_o   = rst_i && (start_ok || (state_reg == BUSY));
  assign md.done_o   = done_w;
  assign md.result_o = done_w ? res_pend_reg : res_last_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed corner cases, random ops against
// a behavioural model, flush and asynchronous reset mid-operation.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  ex_muldiv_if md();

  ex_muldiv #(.XLEN(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .md(md));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic [31:0] exp;
    int          cyc;
    string       tag;
  } sb_t;
  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, ua, sb, ub, p;
    sa = {{32{a[31]}}, a};
    ua = {32'h0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'h0, b};
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      MD_DIVU: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      MD_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Monitor: counts the busy run and retires scoreboard entries on done_o.
  int busy_cnt = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk_i) begin
    sb_t e;
    if (!rst_i) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (md.busy_o && !prev_busy) busy_cnt = 0;
      if (md.busy_o) busy_cnt++;
      prev_busy = md.busy_o;
      if (md.done_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk({e.tag, "_res"}, md.result_o, e.exp);
          chk({e.tag, "_lat"}, 32'(cyc - e.cyc), 32'd33);
          chk({e.tag, "_busy"}, 32'(busy_cnt), 32'd33);
          $display("op %-12s result=%h expect=%h cycle=%0d", e.tag, md.result_o, e.exp, cyc);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following done_o.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    bit seen = 1'b0;
    md.start_i = 1'b1;
    md.op_i    = op;
    md.rs1_i   = a;
    md.rs2_i   = b;
    sb_q.push_back('{exp, cyc, tag});
    last_exp = exp;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk_i);
      seen = md.done_o;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    @(posedge clk_i); #1;
    md.start_i = 1'b0;
  endtask

  localparam int NDIR = 14;
  logic [2:0]  d_op  [NDIR] = '{MD_MUL, MD_MULHU, MD_MULH, MD_MULHSU, MD_DIV, MD_REM, MD_DIVU,
                                MD_REMU, MD_DIVU, MD_REM, MD_DIV, MD_REM, MD_MUL, MD_MULH};
  logic [31:0] d_a   [NDIR] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000,
                                32'h80000000, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] d_b   [NDIR] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7,
                                32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000};
  logic [31:0] d_exp [NDIR] = '{32'h0000002A, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF,
                                32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0000000E, 32'h00000002,
                                32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h00000000,
                                32'h00000001, 32'h40000000};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    md.start_i = 1'b0;
    md.flush_i = 1'b0;
    md.op_i    = 3'b000;
    md.rs1_i   = '0;
    md.rs2_i   = '0;
    rst_i      = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", {31'b0, md.busy_o}, 32'd0);
    chk("rst_done", {31'b0, md.done_o}, 32'd0);
    chk("rst_result", md.result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < NDIR; i++)
      do_op(d_op[i], d_a[i], d_b[i], d_exp[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      do_op(rop, ra, rb, ref_md(rop, ra, rb), $sformatf("rnd%0d", i));
    end

    // Flush a DIV in its 10th cycle, then start MUL 3x3 two cycles later.
    md.start_i = 1'b1;
    md.op_i    = MD_DIV;
    md.rs1_i   = 32'd1000;
    md.rs2_i   = 32'd3;
    repeat (10) @(posedge clk_i);
    #1 md.flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_done", {31'b0, md.done_o}, 32'd0);
    @(posedge clk_i); #1;
    md.flush_i = 1'b0;
    md.start_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy", {31'b0, md.busy_o}, 32'd0);
    chk("flush_done2", {31'b0, md.done_o}, 32'd0);
    chk("flush_result", md.result_o, last_exp);
    @(posedge clk_i); #1;
    do_op(MD_MUL, 32'd3, 32'd3, 32'd9, "post_flush");

    // Asynchronous reset in the middle of a MUL.
    md.start_i = 1'b1;
    md.op_i    = MD_MUL;
    md.rs1_i   = 32'd5;
    md.rs2_i   = 32'd5;
    repeat (20) @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1;
    chk("arst_busy", {31'b0, md.busy_o}, 32'd0);
    chk("arst_done", {31'b0, md.done_o}, 32'd0);
    chk("arst_result", md.result_o, 32'd0);
    md.start_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (md.done_o || md.busy_o) chk($sformatf("arst_idle%0d", k), {30'b0, md.busy_o, md.done_o}, 32'd0);
    end
    chk("arst_idle_done", {31'b0, md.done_o}, 32'd0);
    chk("arst_idle_result", md.result_o, 32'd0);
    @(posedge clk_i); #1;
    do_op(MD_REMU, 32'd100, 32'd7, 32'd2, "post_reset");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
